pulse_train_gen: RTL
====================

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter: CNT_W, default 8, width of length and count fields.
REQ-002 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin a pulse train; sampled at posedge clk.
REQ-005 Port: abort  input  1  request to terminate a running train; sampled at posedge clk.
REQ-006 Port: high_len  input  CNT_W  high-phase length, in clk cycles, per pulse.
REQ-007 Port: low_len  input  CNT_W  low-phase length, in clk cycles, per pulse.
REQ-008 Port: num_pulses  input  CNT_W  number of pulses in the train.
REQ-009 Port: data_out  output  1  generated waveform, registered.
REQ-010 Port: pos_evt  output  1  one-cycle strobe, high in the first cycle data_out is 1 after being 0.
REQ-011 Port: neg_evt  output  1  one-cycle strobe, high in the first cycle data_out is 0 after being 1.
REQ-012 Port: busy  output  1  high while state is HIGH or LOW.
REQ-013 Port: done  output  1  one-cycle strobe at train completion or abort.

Function
REQ-014 FSM states SHALL be IDLE, HIGH and LOW; all outputs SHALL be registered.
REQ-015 In IDLE, start=1 with abort=0 and num_pulses!=0: SHALL latch high_len, low_len and num_pulses, then enter HIGH on the next cycle with data_out=1 and pos_evt=1.
REQ-016 In IDLE, start with num_pulses=0: SHALL be ignored, with no done.
REQ-017 A high_len or low_len of 0 SHALL be treated as 1.
REQ-018 HIGH SHALL last exactly the latched high_len cycles with data_out=1, then transition to LOW.
REQ-019 LOW SHALL last exactly the latched low_len cycles with data_out=0; neg_evt=1 in its first cycle.
REQ-020 At the end of LOW: if pulses remain, SHALL re-enter HIGH with pos_evt=1; otherwise SHALL enter IDLE with done=1 for one cycle and busy=0.
REQ-021 Every pulse, including the last, SHALL include its full low phase, so back-to-back trains keep a low gap of at least low_len cycles.
REQ-022 start while busy=1 SHALL be ignored; latched parameters SHALL NOT change mid-train.
REQ-023 abort=1 while busy: next cycle SHALL be IDLE, data_out=0, done=1; neg_evt=1 only if data_out was 1.
REQ-024 abort=1 in IDLE SHALL have no effect and SHALL take priority over a simultaneous start.
REQ-025 Counters SHALL be CNT_W bits, count down, and never wrap; max values (2^CNT_W-1) SHALL be honoured exactly.
REQ-026 pos_evt and neg_evt SHALL never be high in the same cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, data_out=0, pos_evt=0, neg_evt=0, busy=0, done=0, and clear all counters, including mid-train.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first posedge clk.

Structure
REQ-029 The FSM state enum and the CNT_W default SHALL live in the shared package pulse_pkg.
REQ-030 Phase timing SHALL use one sub-module, phase_counter: a loadable CNT_W down-counter with a terminal-count flag, instantiated once and reloaded per phase.

Verification
REQ-031 high_len=3, low_len=2, num_pulses=2 -> data_out 1,1,1,0,0,1,1,1,0,0; pos_evt at cycles 1 and 6; neg_evt at cycles 4 and 9; done at cycle 11.
REQ-032 high_len=0, low_len=0, num_pulses=1 -> data_out 1,0; done in the following cycle.
REQ-033 num_pulses=0 with start -> no output activity; busy stays 0.
REQ-034 abort in the 2nd HIGH cycle of high_len=5 -> next cycle data_out=0, neg_evt=1, done=1, busy=0.
REQ-035 start pulsed during a train -> ignored; waveform identical to the undisturbed train.
REQ-036 rst_n=0 mid-HIGH -> outputs 0 immediately, without waiting for clk; new train after release runs normally.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse train generator.
//   CNT_W_DEFAULT : default width of the length/count fields
//   state_e       : top-level FSM state encoding
package pulse_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that times one phase (HIGH or LOW) of a pulse.
//   clk      : clock
//   rst_n    : asynchronous active-low reset, clears the count
//   load     : load load_val into the counter (takes priority over en)
//   load_val : phase length in cycles
//   en       : decrement by one, saturating at zero
//   tc       : terminal count, the current cycle is the last of the phase
module phase_counter
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count holds the cycles remaining including the current one.
  assign tc = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits num_pulses pulses of high_len high cycles followed by
// low_len low cycles each. Every output is registered.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   start      : begin a train (ignored while busy or when num_pulses is 0)
//   abort      : terminate a running train (wins over start)
//   high_len   : high-phase length in cycles (0 behaves as 1)
//   low_len    : low-phase length in cycles (0 behaves as 1)
//   num_pulses : pulses per train
//   data_out   : generated waveform
//   pos_evt    : strobe on the first high cycle of each pulse
//   neg_evt    : strobe on the first low cycle after a high cycle
//   busy       : train in progress
//   done       : strobe when the train completes or is aborted
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] num_pulses,
  output logic             data_out,
  output logic             pos_evt,
  output logic             neg_evt,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] pulses_q, pulses_d;

  logic             ph_load;
  logic [CNT_W-1:0] ph_load_val;
  logic             ph_en;
  logic             ph_tc;

  logic             data_d, pos_d, neg_d, busy_d, done_d;
  logic             data_q, pos_q, neg_q, busy_q, done_q;

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ph_load),
    .load_val (ph_load_val),
    .en       (ph_en),
    .tc       (ph_tc)
  );

  always_comb begin
    state_d     = state_q;
    high_d      = high_q;
    low_d       = low_q;
    pulses_d    = pulses_q;
    ph_load     = 1'b0;
    ph_load_val = high_q;
    ph_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort && (num_pulses != '0)) begin
          // Zero lengths are stored as 1 so the phase counter never sees 0.
          high_d      = (high_len == '0) ? CNT_W'(1) : high_len;
          low_d       = (low_len == '0) ? CNT_W'(1) : low_len;
          pulses_d    = num_pulses;
          ph_load     = 1'b1;
          ph_load_val = high_d;
          state_d     = StHigh;
        end
      end
      StHigh: begin
        if (abort) begin
          pulses_d = '0;
          state_d  = StIdle;
        end else if (ph_tc) begin
          ph_load     = 1'b1;
          ph_load_val = low_q;
          state_d     = StLow;
        end else begin
          ph_en = 1'b1;
        end
      end
      StLow: begin
        if (abort) begin
          pulses_d = '0;
          state_d  = StIdle;
        end else if (ph_tc) begin
          if (pulses_q > CNT_W'(1)) begin
            pulses_d    = pulses_q - CNT_W'(1);
            ph_load     = 1'b1;
            ph_load_val = high_q;
            state_d     = StHigh;
          end else begin
            pulses_d = '0;
            state_d  = StIdle;
          end
        end else begin
          ph_en = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    data_d = (state_d == StHigh);
    busy_d = (state_d != StIdle);
    pos_d  = data_d && !data_q;
    neg_d  = !data_d && data_q;
    done_d = (state_q != StIdle) && (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      high_q   <= '0;
      low_q    <= '0;
      pulses_q <= '0;
      data_q   <= 1'b0;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      high_q   <= high_d;
      low_q    <= low_d;
      pulses_q <= pulses_d;
      data_q   <= data_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign data_out = data_q;
  assign pos_evt  = pos_q;
  assign neg_evt  = neg_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
